ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction-fetch stage. Produces the instruction stream consumed by the decode stage: `inst`, fetch-side exception flag/code, and the PC.
- Owns the PC register and the SRAM-like instruction-memory handshake.
- Applies redirects from exception flush, ERET and resolved branches, honouring the MIPS branch delay slot.
- Holds at most one instruction beyond decode: outstanding request plus output buffer ≤ 1.

Parameters:
RESET_PC  32'hBFC00000  PC of the first fetch after reset
EX_ENTRY  32'hBFC00380  exception vector

Ports:
clk            in   1   clock
resetn         in   1   asynchronous active-low reset
inst_req       out  1   instruction memory request
inst_addr      out  32  request address, word aligned
inst_addr_ok   in   1   request accepted this cycle
inst_data_ok   in   1   read data valid this cycle
inst_rdata     in   32  read data
if_valid       out  1   output entry valid for decode
if_pc          out  32  PC of output entry
if_inst        out  32  instruction of output entry
if_cp0_ex      out  1   fetch exception on entry
if_cp0_excode  out  5   exception code, 5'h04 (ADEL) when if_cp0_ex
id_allowin     in   1   decode consumes entry when if_valid && id_allowin
br_redirect    in   1   one-cycle pulse: branch/jump in decode taken
br_slot_pc     in   32  delay-slot PC (branch PC + 4)
br_target      in   32  branch/jump target
ex_flush       in   1   exception commit pulse
eret_flush     in   1   ERET commit pulse
cp0_epc        in   32  ERET return address

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC; state=IDLE; buffer empty; pend_valid=0.
  - if_valid=0, inst_req=0, if_inst=0, if_pc=0, if_cp0_ex=0, if_cp0_excode=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: address accepted, data pending.
  - DISCARD: flushed while data pending; the returning data is dropped.
- Issue rule, IDLE only:
  - Issue requires the buffer to be empty, or to be consumed this cycle.
  - If pc[1:0]==0: inst_req=1, inst_addr=pc. When inst_addr_ok=1: go to WAIT, pc advances per the next-PC rule.
  - If pc[1:0]!=0: no request. Load the buffer with inst=0, if_cp0_ex=1, excode=5'h04, pc=pc. The next pc is pc+4 (decode/commit flushes it).
- WAIT:
  - On inst_data_ok: buffer ← {inst_rdata, pc of request, ex=0}, go to IDLE.
  - Data may arrive the cycle after addr_ok or later.
- Next-PC rule when a request (or ADEL entry) is issued at address A:
  - If pend_valid and A==br_slot_pc latched: pc ← pend_target, pend_valid ← 0.
  - Otherwise pc ← A+4.
- br_redirect:
  - If the slot is not yet issued (pc==br_slot_pc and state IDLE): latch pend_target=br_target, pend_valid=1.
  - Otherwise the slot is already in flight or buffered: pc ← br_target immediately.
  - No instruction beyond the slot is ever in flight, by the ≤1 rule.
- Flush priority: ex_flush > eret_flush > br_redirect.
  - Target is EX_ENTRY for ex_flush, cp0_epc for eret_flush.
  - On either flush: buffer cleared; pend_valid=0; pc ← target.
  - WAIT goes to DISCARD. A same-cycle inst_data_ok is dropped and the state goes to IDLE.
  - A request in IDLE is suppressed that cycle.
- DISCARD: the next inst_data_ok is dropped, then IDLE. A new flush in DISCARD only updates pc.
- Output:
  - if_* reflect the buffer.
  - Held stable while if_valid && !id_allowin.
  - Cleared on consumption unless reloaded the same cycle.
- inst_req is held until inst_addr_ok; inst_addr is stable while inst_req is held.
  - A flush during an unaccepted request drops that request and re-requests the new pc next cycle.

Test Plan:
- Reset release, memory returns data_ok one cycle after addr_ok → requests at BFC00000, BFC00004, BFC00008 in order; each delivered with if_valid, correct if_pc/if_inst, ex=0.
- id_allowin=0 for 5 cycles with an entry buffered → if_* stable; no new inst_req; resumes in order after id_allowin=1.
- br_redirect (slot BFC00010 not yet issued, target 80001000) → next fetches are BFC00010 then 80001000; also the slot-in-flight case → the next fetch is 80001000 with no skipped or duplicated slot.
- ex_flush while in WAIT, data arriving 3 cycles later → that data discarded, first delivered entry is pc=BFC00380.
- eret_flush with cp0_epc=80000002 → no memory request; entry if_pc=80000002, if_cp0_ex=1, if_cp0_excode=5'h04, if_inst=0.
- resetn asserted mid-WAIT → outputs immediately zero/invalid; after release fetch restarts at BFC00000; the stale data_ok is ignored.

Source files
------------

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, drives the SRAM-like instruction port and
// keeps a single output entry for decode, with flush, ERET and delayed-branch redirects.
//
// state     | meaning
// S_IDLE    | no request outstanding; may raise inst_req or load an ADEL entry
// S_WAIT    | address accepted, read data pending
// S_DISCARD | flushed while data pending; the next inst_data_ok is dropped
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000,
   parameter logic [31:0] EX_ENTRY = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_cp0_ex,
   output logic [4:0]  if_cp0_excode,
   input  logic        id_allowin,
   input  logic        br_redirect,
   input  logic [31:0] br_slot_pc,
   input  logic [31:0] br_target,
   input  logic        ex_flush,
   input  logic        eret_flush,
   input  logic [31:0] cp0_epc
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_req;
   logic [31:0] r_fetch_pc;
   logic        r_pend_valid;
   logic [31:0] r_pend_slot;
   logic [31:0] r_pend_target;
   logic        r_buf_valid;
   logic [31:0] r_buf_pc;
   logic [31:0] r_buf_inst;
   logic        r_buf_ex;

   logic        w_flush;
   logic [31:0] w_flush_pc;
   logic        w_idle;
   logic        w_buf_free;
   logic        w_br_pend;
   logic        w_br_now;
   logic        w_fire;
   logic        w_adel;
   logic        w_pend_hit;
   logic [31:0] w_next_pc;

   assign w_flush    = ex_flush | eret_flush;
   assign w_flush_pc = ex_flush ? EX_ENTRY : cp0_epc;
   assign w_idle     = (r_state == S_IDLE);
   assign w_buf_free = !r_buf_valid || id_allowin;

   // Slot not yet issued: defer the target until the slot address goes out.
   assign w_br_pend  = br_redirect && w_idle && (r_pc == br_slot_pc);
   assign w_br_now   = br_redirect && !w_br_pend;

   assign inst_req   = r_req && !w_flush && !w_br_now;
   assign inst_addr  = r_pc;
   assign w_fire     = inst_req && inst_addr_ok;
   assign w_adel     = w_idle && !r_req && w_buf_free && (r_pc[1:0] != 2'b00)
                       && !w_flush && !w_br_now;

   assign w_pend_hit = r_pend_valid && (r_pc == r_pend_slot);
   assign w_next_pc  = w_br_pend  ? br_target :
                       w_pend_hit ? r_pend_target : r_pc + 32'd4;

   assign if_valid      = r_buf_valid;
   assign if_pc         = r_buf_pc;
   assign if_inst       = r_buf_inst;
   assign if_cp0_ex     = r_buf_ex;
   assign if_cp0_excode = r_buf_ex ? 5'h04 : 5'h00;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_req         <= 1'b0;
         r_fetch_pc    <= 32'd0;
         r_pend_valid  <= 1'b0;
         r_pend_slot   <= 32'd0;
         r_pend_target <= 32'd0;
         r_buf_valid   <= 1'b0;
         r_buf_pc      <= 32'd0;
         r_buf_inst    <= 32'd0;
         r_buf_ex      <= 1'b0;
      end else if (w_flush) begin
         r_pc         <= w_flush_pc;
         r_req        <= 1'b0;
         r_pend_valid <= 1'b0;
         r_buf_valid  <= 1'b0;
         r_buf_pc     <= 32'd0;
         r_buf_inst   <= 32'd0;
         r_buf_ex     <= 1'b0;
         if (r_state == S_WAIT)
            r_state <= inst_data_ok ? S_IDLE : S_DISCARD;
         else if (r_state == S_DISCARD && inst_data_ok)
            r_state <= S_IDLE;
      end else begin
         if (w_br_now)
            r_pc <= br_target;
         else if (w_fire || w_adel)
            r_pc <= w_next_pc;

         if (w_fire || w_br_now)
            r_req <= 1'b0;
         else if (w_idle && w_buf_free && (r_pc[1:0] == 2'b00))
            r_req <= 1'b1;

         if (w_br_pend && !w_fire && !w_adel) begin
            r_pend_valid  <= 1'b1;
            r_pend_slot   <= br_slot_pc;
            r_pend_target <= br_target;
         end else if ((w_fire || w_adel) && (w_br_pend || w_pend_hit)) begin
            r_pend_valid <= 1'b0;
         end

         if (w_fire)
            r_fetch_pc <= r_pc;

         // A reload in the same cycle as consumption wins over the clear.
         if (r_state == S_WAIT && inst_data_ok) begin
            r_buf_valid <= 1'b1;
            r_buf_pc    <= r_fetch_pc;
            r_buf_inst  <= inst_rdata;
            r_buf_ex    <= 1'b0;
         end else if (w_adel) begin
            r_buf_valid <= 1'b1;
            r_buf_pc    <= r_pc;
            r_buf_inst  <= 32'd0;
            r_buf_ex    <= 1'b1;
         end else if (r_buf_valid && id_allowin) begin
            r_buf_valid <= 1'b0;
            r_buf_pc    <= 32'd0;
            r_buf_inst  <= 32'd0;
            r_buf_ex    <= 1'b0;
         end

         case (r_state)
            S_IDLE:    if (w_fire) r_state <= S_WAIT;
            S_WAIT:    if (inst_data_ok) r_state <= S_IDLE;
            S_DISCARD: if (inst_data_ok) r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: random memory latency, decode stalls, branches and flushes,
// checked against an architectural next-PC model and a simple instruction memory.
module tb_ifetch;

   localparam logic [31:0] RESET_PC = 32'hBFC00000;
   localparam logic [31:0] EX_ENTRY = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = 32'd0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_cp0_ex;
   logic [4:0]  if_cp0_excode;
   logic        id_allowin = 1'b0;
   logic        br_redirect = 1'b0;
   logic [31:0] br_slot_pc = 32'd0;
   logic [31:0] br_target = 32'd0;
   logic        ex_flush = 1'b0;
   logic        eret_flush = 1'b0;
   logic [31:0] cp0_epc = 32'd0;

   always #5 clk = ~clk;

   ifetch dut (
      .clk           (clk),
      .resetn        (resetn),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_addr_ok  (inst_addr_ok),
      .inst_data_ok  (inst_data_ok),
      .inst_rdata    (inst_rdata),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_inst       (if_inst),
      .if_cp0_ex     (if_cp0_ex),
      .if_cp0_excode (if_cp0_excode),
      .id_allowin    (id_allowin),
      .br_redirect   (br_redirect),
      .br_slot_pc    (br_slot_pc),
      .br_target     (br_target),
      .ex_flush      (ex_flush),
      .eret_flush    (eret_flush),
      .cp0_epc       (cp0_epc)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   // architectural model: next PC decode must see
   logic [31:0] exp_pc = RESET_PC;
   bit          armed = 0;
   logic [31:0] arm_tgt = 32'd0;
   bit          br_sched = 0;
   logic [31:0] br_sched_slot = 32'd0;
   logic [31:0] br_sched_tgt = 32'd0;

   // memory model
   bit          mem_busy = 0;
   logic [31:0] mem_addr = 32'd0;
   int          mem_lat = 0;
   bit          inject_stale = 0;

   // previous-cycle observations
   bit          p_hold = 0;
   logic [31:0] p_pc, p_inst;
   logic        p_ex;
   logic [4:0]  p_code;
   bit          p_req_wait = 0;
   logic [31:0] p_addr;

   int n_consumed = 0;
   int idle_cnt   = 0;
   bit abort      = 0;

   task automatic do_cycle(input bit rnd);
      bit          fl_ex, fl_er, acc, e_ex;
      logic [31:0] acc_addr, pc_cur;
      @(negedge clk);
      inst_data_ok = (mem_busy && mem_lat == 0) || inject_stale;
      inst_rdata   = inject_stale ? 32'hDEAD_BEEF : mem_fn(mem_addr);
      inject_stale = 0;
      br_redirect  = br_sched;
      br_slot_pc   = br_sched_slot;
      br_target    = br_sched_tgt;
      br_sched     = 0;
      fl_ex = rnd && ($urandom_range(0, 59) == 0);
      fl_er = rnd && ($urandom_range(0, 49) == 0);
      ex_flush   = fl_ex;
      eret_flush = fl_er;
      cp0_epc = 32'h8000_0000 | ($urandom & 32'h0000_FFF0);
      if ($urandom_range(0, 2) == 0) cp0_epc = cp0_epc | 32'($urandom_range(1, 3));
      if (fl_ex) begin exp_pc = EX_ENTRY; armed = 0; end
      else if (fl_er) begin exp_pc = cp0_epc; armed = 0; end
      id_allowin = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (p_hold) begin
         check("stall_valid", if_valid, 1'b1);
         check("stall_pc", if_pc, p_pc);
         check("stall_inst", if_inst, p_inst);
         check("stall_ex", if_cp0_ex, p_ex);
         check("stall_code", if_cp0_excode, p_code);
      end
      if (p_req_wait && !fl_ex && !fl_er && !br_redirect) begin
         check("req_held", inst_req, 1'b1);
         check("addr_held", inst_addr, p_addr);
      end
      if (inst_req) check("addr_align", inst_addr[1:0], 2'b00);
      check("req_while_busy", inst_req && mem_busy, 1'b0);
      check("at_most_one", ((mem_busy ? 1 : 0) + (if_valid ? 1 : 0)) <= 1, 1'b1);
      if (if_valid && id_allowin && !fl_ex && !fl_er) begin
         pc_cur = exp_pc;
         e_ex   = (pc_cur[1:0] != 2'b00);
         check("if_pc", if_pc, pc_cur);
         check("if_ex", if_cp0_ex, e_ex);
         check("if_inst", if_inst, e_ex ? 32'd0 : mem_fn(pc_cur));
         if (e_ex) check("if_excode", if_cp0_excode, 5'h04);
         n_consumed++;
         idle_cnt = 0;
         if (armed) begin
            exp_pc = arm_tgt;
            armed  = 0;
         end else if (rnd && !e_ex && $urandom_range(0, 3) == 0) begin
            br_sched      = 1;
            br_sched_slot = pc_cur + 32'd4;
            br_sched_tgt  = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
            armed         = 1;
            arm_tgt       = br_sched_tgt;
            exp_pc        = pc_cur + 32'd4;
         end else begin
            exp_pc = pc_cur + 32'd4;
         end
      end else begin
         idle_cnt++;
         if (idle_cnt > 400) begin
            check("progress_timeout", idle_cnt, 0);
            abort = 1;
         end
      end
      inst_addr_ok = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      acc      = inst_req && inst_addr_ok;
      acc_addr = inst_addr;
      p_hold     = if_valid && !id_allowin && !fl_ex && !fl_er;
      p_pc       = if_pc;
      p_inst     = if_inst;
      p_ex       = if_cp0_ex;
      p_code     = if_cp0_excode;
      p_req_wait = inst_req && !acc;
      p_addr     = inst_addr;
      @(posedge clk);
      if (mem_busy) begin
         if (mem_lat == 0) mem_busy = 0;
         else mem_lat--;
      end
      if (acc) begin
         mem_busy = 1;
         mem_addr = acc_addr;
         mem_lat  = rnd ? int'($urandom_range(0, 3)) : 0;
      end
   endtask

   task automatic clear_inputs();
      inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0; id_allowin = 0;
      br_redirect = 0; ex_flush = 0; eret_flush = 0;
   endtask

   task automatic reset_model();
      exp_pc = RESET_PC; armed = 0; br_sched = 0;
      mem_busy = 0; mem_lat = 0; p_hold = 0; p_req_wait = 0; idle_cnt = 0;
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_if_valid"}, if_valid, 1'b0);
      check({pfx, "_inst_req"}, inst_req, 1'b0);
      check({pfx, "_if_pc"}, if_pc, 32'd0);
      check({pfx, "_if_inst"}, if_inst, 32'd0);
      check({pfx, "_if_ex"}, if_cp0_ex, 1'b0);
      check({pfx, "_if_excode"}, if_cp0_excode, 5'h00);
   endtask

   initial begin
      int start_cnt;
      clear_inputs();
      resetn = 0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk) resetn = 1;
      reset_model();

      // in-order startup with single-cycle memory and no stalls
      for (int i = 0; i < 40 && !abort; i++) do_cycle(0);
      check("startup_entries", n_consumed >= 8, 1'b1);

      for (int i = 0; i < 3000 && !abort; i++) do_cycle(1);

      // asynchronous reset while a fetch is outstanding
      for (int i = 0; i < 200 && !mem_busy && !abort; i++) do_cycle(1);
      check("reach_wait", mem_busy, 1'b1);
      #2 resetn = 0;
      clear_inputs();
      #1 check_zero("midwait");
      @(negedge clk);
      @(negedge clk) resetn = 1;
      reset_model();
      inject_stale = 1;
      start_cnt = n_consumed;
      for (int i = 0; i < 40 && !abort; i++) do_cycle(0);
      check("restart_entries", (n_consumed - start_cnt) >= 8, 1'b1);
      for (int i = 0; i < 1500 && !abort; i++) do_cycle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
